// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the LTC2624 SPI DAC frame writer.
//   state_e     : frame engine states
//   frame_t     : 32-bit write-and-update frame layout, MSB shifted first
//   frame_word  : assembles a frame from address nibble and 12-bit sample
package dac_spi_pkg;

  localparam int unsigned FRAME_BITS  = 32;
  localparam int unsigned SAMPLE_BITS = 12;
  localparam int unsigned BIT_CNT_W   = 5;

  // LTC2624 command nibble: write input register and update DAC output
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_GAP,
    ST_CLEAR
  } state_e;

  typedef struct packed {
    logic [7:0]             pad;
    logic [3:0]             cmd;
    logic [3:0]             addr;
    logic [SAMPLE_BITS-1:0] sample;
    logic [3:0]             tail;
  } frame_t;

  function automatic frame_t frame_word(input logic [3:0] addr,
                                        input logic [SAMPLE_BITS-1:0] sample);
    frame_t f;
    f.pad    = 8'h00;
    f.cmd    = CMD_WRITE_UPDATE;
    f.addr   = addr;
    f.sample = sample;
    f.tail   = 4'h0;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_sck_gen.sv
// SPI clock generator: counts SCK_DIV clock cycles per SCK half-period while
// enabled and toggles the registered SCK level at each half-period boundary.
//   clk_i         : system clock
//   rst_i         : synchronous reset, active-high
//   en_i          : run; when low the phase counter and SCK are held at 0
//   half_tick_c_o : last cycle of the current half-period (combinational)
//   sck_o         : registered SCK level, idle low
module dac_spi_sck_gen #(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic half_tick_c_o,
  output logic sck_o
);

  localparam int unsigned PH_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [PH_W-1:0] phase_q;
  logic            sck_q;

  assign half_tick_c_o = en_i && (phase_q == PH_W'(SCK_DIV - 1));
  assign sck_o         = sck_q;

  // Phase counter restarts at each half-period; SCK toggles on the tick
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      phase_q <= '0;
      sck_q   <= 1'b0;
    end else if (half_tick_c_o) begin
      phase_q <= '0;
      sck_q   <= ~sck_q;
    end else begin
      phase_q <= phase_q + PH_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
// LTC2624 frame engine: accepts one 12-bit sample per handshake and shifts a
// 32-bit write-and-update frame out MSB first, then holds CS high for CS_GAP
// cycles before accepting the next sample. All outputs are registered.
// Optional startup clear: define DAC_SPI_STARTUP_CLR_EN to pulse DAC_CLR low
// for CLR_CYCLES cycles after reset (READY low meanwhile).
//   IN_CLOCK     : system clock
//   IN_RESET     : synchronous reset, active-high
//   IN_BITS      : unsigned sample, captured on IN_VALID & OUT_READY
//   IN_VALID     : sample valid strobe
//   OUT_READY    : engine idle
//   OUT_SPI_SCK  : SPI clock, idle low
//   OUT_SPI_MOSI : serial data, MSB first
//   OUT_DAC_CS   : chip select, active-low
//   OUT_DAC_CLR  : DAC clear, active-low
module dac_spi_writer
  import dac_spi_pkg::*;
#(
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned CS_GAP     = 4,
  parameter logic [3:0]  DAC_ADDR   = 4'hF,
  parameter int unsigned CLR_CYCLES = 16
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic [SAMPLE_BITS-1:0] IN_BITS,
  input  logic                   IN_VALID,
  output logic                   OUT_READY,
  output logic                   OUT_SPI_SCK,
  output logic                   OUT_SPI_MOSI,
  output logic                   OUT_DAC_CS,
  output logic                   OUT_DAC_CLR
);

  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  // Elaboration-time parameter sanity checks
  if (SCK_DIV == 0) begin : g_bad_sck_div
    $error("SCK_DIV must be at least 1");
  end
  if (CS_GAP == 0) begin : g_bad_cs_gap
    $error("CS_GAP must be at least 1");
  end
  if (CLR_CYCLES == 0) begin : g_bad_clr_cycles
    $error("CLR_CYCLES must be at least 1");
  end

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic                   ready_q;
  logic                   cs_q;
  logic                   sck_en;
  logic                   half_tick;
  logic                   sck;
  logic                   last_bit;

  assign sck_en   = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

  dac_spi_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk_i         (IN_CLOCK),
    .rst_i         (IN_RESET),
    .en_i          (sck_en),
    .half_tick_c_o (half_tick),
    .sck_o         (sck)
  );

  // Next shift-register contents and bit count for the following bit
  always_comb begin
    shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
  end

`ifdef DAC_SPI_STARTUP_CLR_EN
  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  logic [CLR_W-1:0] clr_cnt_q;
  logic             clr_q;
`endif

  // Frame FSM; MOSI is the shift register MSB, zeroed outside a frame
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
`ifdef DAC_SPI_STARTUP_CLR_EN
      state_q   <= ST_CLEAR;
      ready_q   <= 1'b0;
      clr_q     <= 1'b0;
      clr_cnt_q <= '0;
`else
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
`endif
      cs_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            shift_q   <= frame_word(DAC_ADDR, IN_BITS);
            bit_cnt_q <= '0;
            cs_q      <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (half_tick) begin
            state_q <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (half_tick) begin
            if (last_bit) begin
              shift_q   <= '0;
              cs_q      <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= ST_GAP;
            end else begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              state_q   <= ST_SHIFT_LO;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
`ifdef DAC_SPI_STARTUP_CLR_EN
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
            clr_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          end
        end
`endif
        default: begin
          shift_q <= '0;
          cs_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign OUT_READY    = ready_q;
  assign OUT_SPI_SCK  = sck;
  assign OUT_SPI_MOSI = shift_q[FRAME_BITS-1];
  assign OUT_DAC_CS   = cs_q;
`ifdef DAC_SPI_STARTUP_CLR_EN
  assign OUT_DAC_CLR  = clr_q;
`else
  assign OUT_DAC_CLR  = 1'b1;
`endif

endmodule
